// File: rtl/fitbit_display_pkg.sv
// Shared constants and types for the Fitbit display slot scheduler:
// MODE codes, the display ceiling, the scheduler state type and a saturation helper.
package fitbit_display_pkg;

    localparam logic [2:0] MODE_STEPS   = 3'd0;
    localparam logic [2:0] MODE_DIST    = 3'd1;
    localparam logic [2:0] MODE_OVER32  = 3'd2;
    localparam logic [2:0] MODE_HIGHACT = 3'd3;

    localparam logic [13:0] DISPLAY_MAX = 14'd9999;

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } dispState_t;

    // The 4-digit display cannot show more than 9999, so larger sources are clamped.
    function automatic logic [13:0] saturate(input logic [13:0] value);
        return (value > DISPLAY_MAX) ? DISPLAY_MAX : value;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts 0..TICK_DIV-1 and pulses tick for one cycle at the wrap.
module tick_prescaler #(
    parameter int TICK_DIV = 100
) (
    input  logic CLK,
    input  logic RESET,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/fitbit_display_scheduler.sv
// Rotates the seven-segment display through the four statistics slots with hold/advance control.
// Define BLANK_GAP_EN to insert a blanked GAP period between slots; otherwise blank is tied 0.
module fitbit_display_scheduler
    import fitbit_display_pkg::*;
#(
    parameter int TICK_DIV    = 100,
    parameter int DWELL_TICKS = 2000,
    parameter int GAP_TICKS   = 250
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [13:0] stepCount,
    input  logic [13:0] distance,
    input  logic [13:0] overThreshSec,
    input  logic [13:0] highActSec,
    input  logic        hold,
    input  logic        advance,
    output logic [2:0]  MODE,
    output logic [13:0] binaryDigit,
    output logic        blank,
    output logic        slotStrobe
);

    localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

    if (TICK_DIV < 1 || DWELL_TICKS < 1 || GAP_TICKS < 1) begin : gBadParams
        $error("fitbit_display_scheduler: TICK_DIV, DWELL_TICKS and GAP_TICKS must all be >= 1");
    end

    logic          tick;
    dispState_t    state, stateNext;
    logic [1:0]    slot, slotNext;
    logic [DW-1:0] dwellCnt, dwellNext;
    logic          strobeNext;
    logic [13:0]   srcNext;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) uPrescaler (
        .CLK   (CLK),
        .RESET (RESET),
        .tick  (tick)
    );

`ifdef BLANK_GAP_EN
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

    logic [GW-1:0] gapCnt, gapNext;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) gapCnt <= '0;
        else        gapCnt <= gapNext;
    end
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= SHOW;
            slot        <= 2'd0;
            dwellCnt    <= '0;
            slotStrobe  <= 1'b0;
            binaryDigit <= '0;
        end else begin
            state       <= stateNext;
            slot        <= slotNext;
            dwellCnt    <= dwellNext;
            slotStrobe  <= strobeNext;
            binaryDigit <= saturate(srcNext);
        end
    end

    // NOTE: every signal written here gets a default first so no path infers a latch.
    always_comb begin
        stateNext  = state;
        slotNext   = slot;
        dwellNext  = dwellCnt;
        strobeNext = 1'b0;
`ifdef BLANK_GAP_EN
        gapNext    = gapCnt;
`endif
        case (state)
            SHOW: begin
                if (tick && !hold) dwellNext = dwellCnt + 1'b1;
                // advance and dwell expiry together still yield a single slot step
                if (advance || (tick && !hold && dwellCnt == DWELL_LAST)) begin
                    slotNext  = slot + 2'd1;
                    dwellNext = '0;
`ifdef BLANK_GAP_EN
                    stateNext = GAP;
                    gapNext   = '0;
`else
                    strobeNext = 1'b1;
`endif
                end
            end
`ifdef BLANK_GAP_EN
            GAP: begin
                if (tick) gapNext = gapCnt + 1'b1;
                if (advance || (tick && gapCnt == GAP_LAST)) begin
                    stateNext  = SHOW;
                    gapNext    = '0;
                    strobeNext = 1'b1;
                end
            end
`endif
            default: stateNext = SHOW;
        endcase
    end

    // The value register follows the slot it will present after this edge.
    always_comb begin
        case (slotNext)
            2'd0:    srcNext = stepCount;
            2'd1:    srcNext = distance;
            2'd2:    srcNext = overThreshSec;
            default: srcNext = highActSec;
        endcase
    end

    always_comb begin
        case (slot)
            2'd0:    MODE = MODE_STEPS;
            2'd1:    MODE = MODE_DIST;
            2'd2:    MODE = MODE_OVER32;
            default: MODE = MODE_HIGHACT;
        endcase
`ifdef BLANK_GAP_EN
        blank = (state == GAP);
`else
        blank = 1'b0;
`endif
    end

endmodule

// File: tb/tb_fitbit_display_scheduler.sv
// Scoreboard bench: a tick/slot reference model queues per-cycle expectations, a monitor checks them.
module tb_fitbit_display_scheduler;

    localparam int TICK_DIV    = 4;
    localparam int DWELL_TICKS = 3;
    localparam int GAP_TICKS   = 2;
`ifdef BLANK_GAP_EN
    localparam int PERIOD = (DWELL_TICKS + GAP_TICKS) * TICK_DIV;
`else
    localparam int PERIOD = DWELL_TICKS * TICK_DIV;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [13:0] stepCount = '0;
    logic [13:0] distance = '0;
    logic [13:0] overThreshSec = '0;
    logic [13:0] highActSec = '0;
    logic        hold = 1'b0;
    logic        advance = 1'b0;
    logic [2:0]  MODE;
    logic [13:0] binaryDigit;
    logic        blank;
    logic        slotStrobe;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int mode;
        int digit;
        int blank;
        int strobe;
    } expT;

    expT expQ[$];

    fitbit_display_scheduler #(
        .TICK_DIV    (TICK_DIV),
        .DWELL_TICKS (DWELL_TICKS),
        .GAP_TICKS   (GAP_TICKS)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .stepCount     (stepCount),
        .distance      (distance),
        .overThreshSec (overThreshSec),
        .highActSec    (highActSec),
        .hold          (hold),
        .advance       (advance),
        .MODE          (MODE),
        .binaryDigit   (binaryDigit),
        .blank         (blank),
        .slotStrobe    (slotStrobe)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int satVal(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic int srcOf(input int s);
        case (s)
            0:       return int'(stepCount);
            1:       return int'(distance);
            2:       return int'(overThreshSec);
            default: return int'(highActSec);
        endcase
    endfunction

    // Reference model: slot rotation described as "ticks shown in this slot reach the dwell".
    initial begin
        int  mCycle = 0;
        int  mSlot = 0;
        int  mTicks = 0;
        int  mGapTicks = 0;
        bit  mGap = 0;
        bit  tickNow;
        expT e;
        forever begin
            @(posedge CLK);
            e.strobe = 0;
            if (!RESET) begin
                mCycle = 0; mSlot = 0; mTicks = 0; mGapTicks = 0; mGap = 0;
                e.mode = 0; e.digit = 0; e.blank = 0;
            end else begin
                tickNow = ((mCycle % TICK_DIV) == TICK_DIV - 1);
                mCycle++;
                if (!mGap) begin
                    if (tickNow && !hold) mTicks++;
                    if (advance || mTicks == DWELL_TICKS) begin
                        mSlot = (mSlot + 1) % 4;
                        mTicks = 0;
`ifdef BLANK_GAP_EN
                        mGap = 1;
                        mGapTicks = 0;
`else
                        e.strobe = 1;
`endif
                    end
                end else begin
                    if (tickNow) mGapTicks++;
                    if (advance || mGapTicks == GAP_TICKS) begin
                        mGap = 0;
                        e.strobe = 1;
                    end
                end
                e.mode  = mSlot;
                e.digit = satVal(srcOf(mSlot));
                e.blank = mGap;
            end
            expQ.push_back(e);
        end
    end

    // Monitor: one expectation per clock, compared on the falling edge.
    initial begin
        expT e;
        forever begin
            @(negedge CLK);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("mon_mode", int'(MODE), e.mode);
                check("mon_digit", int'(binaryDigit), e.digit);
                check("mon_blank", int'(blank), e.blank);
                check("mon_strobe", int'(slotStrobe), e.strobe);
            end
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic waitStrobe(input int budget, output int cycles);
        bit found = 0;
        cycles = 0;
        while (!found && cycles < budget) begin
            step();
            cycles++;
            if (slotStrobe) found = 1;
        end
        if (!found) check("strobe_timeout", 0, 1);
    endtask

    task automatic waitSlot(input int m);
        int cyc;
        int tries = 0;
        do begin
            waitStrobe(4 * PERIOD, cyc);
            tries++;
        end while (int'(MODE) != m && tries < 8);
        if (int'(MODE) != m) check("wait_slot_timeout", int'(MODE), m);
    endtask

    function automatic logic [13:0] randSrc();
        if ($urandom_range(0, 3) == 0) return 14'($urandom_range(9990, 10010));
        return 14'($urandom_range(0, 16383));
    endfunction

    initial begin
        int cyc;
        int cnt;
        int m;
        int expMode[4]  = '{1, 2, 3, 0};
        int expDigit[4] = '{20, 30, 40, 10};

        #1 RESET = 1'b0;
        repeat (3) step();
        check("reset_mode", int'(MODE), 0);
        check("reset_digit", int'(binaryDigit), 0);
        check("reset_blank", int'(blank), 0);
        check("reset_strobe", int'(slotStrobe), 0);

        // Nominal rotation
        stepCount = 14'd10; distance = 14'd20; overThreshSec = 14'd30; highActSec = 14'd40;
        RESET = 1'b1;
        step();
        check("first_mode", int'(MODE), 0);
        check("first_digit", int'(binaryDigit), 10);
        for (int i = 0; i < 4; i++) begin
            waitStrobe(3 * PERIOD, cyc);
            check("rot_mode", int'(MODE), expMode[i]);
            check("rot_digit", int'(binaryDigit), expDigit[i]);
            if (i > 0) check("rot_interval", cyc, PERIOD);
        end

        // Saturation while in slot 0
        stepCount = 14'd12000; step(); check("sat_12000", int'(binaryDigit), 9999);
        stepCount = 14'd5;     step(); check("sat_5", int'(binaryDigit), 5);
        stepCount = 14'd10000; step(); check("sat_10000", int'(binaryDigit), 9999);
        stepCount = 14'd9999;  step(); check("sat_9999", int'(binaryDigit), 9999);
        stepCount = 14'd16383; step(); check("sat_max", int'(binaryDigit), 9999);
        stepCount = 14'd10;

`ifdef BLANK_GAP_EN
        // Gap into slot 2, then an advance that cuts the following gap short
        cnt = 0;
        while (!(blank && MODE == 3'd2) && cnt < 6 * PERIOD) begin step(); cnt++; end
        check("gap_enter_mode", int'(MODE), 2);
        check("gap_enter_blank", int'(blank), 1);
        cnt = 0;
        while (blank && cnt < 50) begin cnt++; step(); end
        check("gap_len", cnt, GAP_TICKS * TICK_DIV);
        check("gap_end_strobe", int'(slotStrobe), 1);
        cnt = 0;
        while (!blank && cnt < 4 * PERIOD) begin step(); cnt++; end
        check("gap2_blank", int'(blank), 1);
        m = int'(MODE);
        step(); step();
        advance = 1'b1;
        step();
        advance = 1'b0;
        check("gap_adv_blank", int'(blank), 0);
        check("gap_adv_mode", int'(MODE), m);
        check("gap_adv_strobe", int'(slotStrobe), 1);
`endif

        // Hold in slot 2
        waitSlot(2);
        step(); step();
        hold = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (slotStrobe) cnt++;
        end
        check("hold_no_strobe", cnt, 0);
        check("hold_mode", int'(MODE), 2);
        hold = 1'b0;
        waitStrobe(3 * PERIOD, cyc);
        check("hold_release_mode", int'(MODE), 3);

        // Advance coinciding with dwell expiry in slot 3
        repeat (DWELL_TICKS * TICK_DIV - 1) step();
        advance = 1'b1;
        step();
        advance = 1'b0;
        check("adv_expiry_mode", int'(MODE), 0);

        // Asynchronous reset mid-dwell in slot 2
        waitSlot(2);
        repeat (5) step();
        #1 RESET = 1'b0;
        #1;
        check("async_rst_mode", int'(MODE), 0);
        check("async_rst_digit", int'(binaryDigit), 0);
        check("async_rst_strobe", int'(slotStrobe), 0);
        check("async_rst_blank", int'(blank), 0);
        step(); step();
        RESET = 1'b1;
        step();
        check("post_rst_mode", int'(MODE), 0);
        check("post_rst_digit", int'(binaryDigit), 10);

        // Randomized traffic, checked by the scoreboard
        for (int i = 0; i < 800; i++) begin
            step();
            advance = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 15) == 0) hold = ~hold;
            if ($urandom_range(0, 3) == 0) stepCount = randSrc();
            if ($urandom_range(0, 3) == 0) distance = randSrc();
            if ($urandom_range(0, 3) == 0) overThreshSec = randSrc();
            if ($urandom_range(0, 3) == 0) highActSec = randSrc();
        end
        advance = 1'b0;
        hold = 1'b0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
